// File: rtl/lisa_rx_fifo.sv
// Oversampled UART receiver feeding a first-word-fall-through FIFO with per-word error flags.
// Parity reception is compiled in only when LISA_RX_PARITY_EN is defined.
module lisa_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DEPTH      = 4,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   baud_ref,
    input  logic                   rxd,
    input  logic                   rd,
    output logic [DATA_BITS-1:0]   d,
    output logic                   data_avail,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   overrun,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

`ifdef LISA_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [1:0]           rxd_sync;
    logic                 baud_q;
    logic                 rd_q;
    logic                 rxd_s;
    logic                 tick;
    logic                 rd_rise;
    logic                 push_c;
    logic                 push_ferr_c;
`ifdef LISA_RX_PARITY_EN
    logic                 perr_q, perr_n;
`endif

    logic [DATA_BITS-1:0] mem_data [DEPTH];
    logic                 mem_ferr [DEPTH];
`ifdef LISA_RX_PARITY_EN
    logic                 mem_perr [DEPTH];
`endif
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]     level_n;
    logic                 pop, wr, drop, full;

    assign rxd_s   = rxd_sync[1];
    assign tick    = baud_ref & ~baud_q;
    assign rd_rise = rd & ~rd_q;

    // Input conditioning: rxd synchronizer (idle-high preset) and edge detectors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_sync <= 2'b11;
            baud_q   <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            rxd_sync <= {rxd_sync[0], rxd};
            baud_q   <= baud_ref;
            rd_q     <= rd;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef LISA_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
`ifdef LISA_RX_PARITY_EN
            perr_q  <= perr_n;
`endif
        end
    end

    // Next-state logic; everything advances only on baud ticks
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        push_c      = 1'b0;
        push_ferr_c = 1'b0;
`ifdef LISA_RX_PARITY_EN
        perr_n      = perr_q;
`endif
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_n = START;
                        cnt_n   = CNT_W'(1);
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        state_n   = rxd_s ? IDLE : DATA;
                        cnt_n     = '0;
                        bit_cnt_n = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n     = '0;
                        shift_n   = {rxd_s, shift[DATA_BITS-1:1]};
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
`ifdef LISA_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
`ifdef LISA_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        perr_n  = rxd_s ^ (^shift) ^ PARITY_ODD;
                        state_n = STOP;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n       = '0;
                        push_c      = 1'b1;
                        push_ferr_c = ~rxd_s;
                        state_n     = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // FIFO control: a pop frees a slot for a same-clk push when full
    assign full = (fifo_level == LVL_FULL);
    assign pop  = rd_rise & data_avail;
    assign wr   = push_c & (~full | pop);
    assign drop = push_c & full & ~pop;

    always_comb begin
        level_n = fifo_level;
        if (wr && !pop) begin
            level_n = fifo_level + LVL_W'(1);
        end else if (!wr && pop) begin
            level_n = fifo_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            data_avail <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= level_n;
            data_avail <= (level_n != '0);
            if (drop) begin
                overrun <= 1'b1;
            end else if (pop) begin
                overrun <= 1'b0;
            end
        end
    end

    // Storage carries no reset; outputs are gated by data_avail instead
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_data[wr_ptr] <= shift;
            mem_ferr[wr_ptr] <= push_ferr_c;
`ifdef LISA_RX_PARITY_EN
            mem_perr[wr_ptr] <= perr_q;
`endif
        end
    end

    assign d         = data_avail ? mem_data[rd_ptr] : '0;
    assign frame_err = data_avail & mem_ferr[rd_ptr];
`ifdef LISA_RX_PARITY_EN
    assign parity_err = data_avail & mem_perr[rd_ptr];
`else
    // No parity bit in this build; the sense parameter has nothing to act on
    assign parity_err = PARITY_ODD & 1'b0;
`endif

endmodule
